// File: rtl/quad_counter.sv
// Quadrature encoder front end: synchronises and filters A/B/index, keeps a wrapping count,
// and provides frame-coherent snapshots. Define QUAD_IDX_RESET_EN to zero the count on armed index.
module quad_counter #(
    parameter int W    = 16,
    parameter int FILT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_en,
    input  logic         enc_a,
    input  logic         enc_b,
    input  logic         enc_idx,
    input  logic         idx_arm,
    input  logic         snap,
    input  logic         clr,
    output logic [W-1:0] count_snap,
    output logic [W-1:0] idx_pos,
    output logic         idx_seen,
    output logic         err,
    output logic         dir
);

    localparam int            RW     = 4;
    localparam logic [RW-1:0] FILT_N = RW'(FILT);

`ifdef QUAD_IDX_RESET_EN
    localparam bit IDX_RESET = 1'b1;
`else
    localparam bit IDX_RESET = 1'b0;
`endif

    typedef enum logic [1:0] {MV_NONE, MV_UP, MV_DN, MV_ERR} move_t;

    function automatic move_t decode(input logic [1:0] old_ab, input logic [1:0] new_ab);
        move_t m;
        m = MV_NONE;
        case ({old_ab, new_ab})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: m = MV_UP;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: m = MV_DN;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: m = MV_ERR;
            default:                            m = MV_NONE;
        endcase
        return m;
    endfunction

    // Stage 0/1: two-flop synchronisers for {A, B, index}
    logic [2:0] sync_p0, sync_p1;
    logic [1:0] ab_s;
    logic       idx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {enc_a, enc_b, enc_idx};
            sync_p1 <= sync_p0;
        end
    end

    assign ab_s  = sync_p1[2:1];
    assign idx_s = sync_p1[0];

    // Stage 2: run-length filters; a run only grows while the same candidate repeats
    logic [1:0]    ab_q, ab_cand, ab_old;
    logic [RW-1:0] ab_run, ab_run_nx;
    logic          primed, step_vld;
    logic          idx_q, idx_cand, idx_d;
    logic [RW-1:0] idx_run, idx_run_nx;

    assign ab_run_nx  = (ab_run != '0 && ab_s == ab_cand) ? ab_run + RW'(1) : RW'(1);
    assign idx_run_nx = (idx_run != '0 && idx_s == idx_cand) ? idx_run + RW'(1) : RW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_q     <= '0;
            ab_cand  <= '0;
            ab_old   <= '0;
            ab_run   <= '0;
            primed   <= 1'b0;
            step_vld <= 1'b0;
        end else begin
            step_vld <= 1'b0;
            if (sample_en) begin
                if (ab_s == ab_q) begin
                    ab_run <= '0;
                end else if (ab_run_nx == FILT_N) begin
                    ab_q     <= ab_s;
                    ab_old   <= ab_q;
                    ab_run   <= '0;
                    primed   <= 1'b1;
                    step_vld <= primed;
                end else begin
                    ab_run  <= ab_run_nx;
                    ab_cand <= ab_s;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= 1'b0;
            idx_cand <= 1'b0;
            idx_run  <= '0;
            idx_d    <= 1'b0;
        end else begin
            idx_d <= idx_q;
            if (sample_en) begin
                if (idx_s == idx_q) begin
                    idx_run <= '0;
                end else if (idx_run_nx == FILT_N) begin
                    idx_q   <= idx_s;
                    idx_run <= '0;
                end else begin
                    idx_run  <= idx_run_nx;
                    idx_cand <= idx_s;
                end
            end
        end
    end

    // Stage 3: decode the accepted transition and update count/flags
    move_t      move;
    logic       capture;
    logic [W-1:0] count;

    assign move    = step_vld ? decode(ab_old, ab_q) : MV_NONE;
    assign capture = idx_q & ~idx_d & idx_arm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            count_snap <= '0;
            idx_pos    <= '0;
            idx_seen   <= 1'b0;
            err        <= 1'b0;
            dir        <= 1'b0;
        end else begin
            if (snap)    count_snap <= count;
            if (capture) idx_pos    <= count;
            if (clr) begin
                count    <= '0;
                err      <= 1'b0;
                idx_seen <= 1'b0;
            end else begin
                if (capture)         idx_seen <= 1'b1;
                if (move == MV_ERR)  err      <= 1'b1;
                if (move == MV_UP)      dir <= 1'b1;
                else if (move == MV_DN) dir <= 1'b0;
                if (capture && IDX_RESET) count <= '0;
                else if (move == MV_UP)   count <= count + W'(1);
                else if (move == MV_DN)   count <= count - W'(1);
            end
        end
    end

endmodule

// File: doc/quad_counter.md
Name: quad_counter

Overview:
- Quadrature encoder front end for the spindle/axis feedback path.
- Filters and decodes A/B/index, maintains a wrapping position count, and presents SPI-frame-coherent snapshots for the readback bytes of the SPI register bank.
- Sits upstream of the SPI slave: its snapshot outputs feed the readback bytes in place of raw din/rpm data.

Parameters:
- W, 16, width of position counter and snapshots
- FILT, 3, consecutive identical qualified samples required to accept a new {A,B} or index level (range 1..15)

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous assert, active-low
- sample_en  input  1  filter sample strobe, one clk wide (tie high for full rate; normally the divider tick)
- enc_a  input  1  encoder channel A, asynchronous
- enc_b  input  1  encoder channel B, asynchronous
- enc_idx  input  1  encoder index, asynchronous
- idx_arm  input  1  level; enables index capture
- snap  input  1  one-cycle pulse at SPI frame start; latches count_snap
- clr  input  1  one-cycle pulse; clears count, err, idx_seen
- count_snap  output  W  count sampled at last snap
- idx_pos  output  W  count captured at last armed index rising edge
- idx_seen  output  1  sticky; set on index capture
- err  output  1  sticky; illegal (double-bit) A/B transition seen
- dir  output  1  direction of last valid step, 1 = up

Behaviour:
- Reset: count, count_snap, idx_pos, idx_seen, err, dir, filter state and the primed flag all 0; asynchronous on rst_n low, released on clk.
- Synchronisers: enc_a, enc_b and enc_idx each pass through 2 flops; filtering uses only the synchronised values.
- AB filter: on each sample_en, compare synced {A,B} with the accepted vector ab_q.
  - If they differ, increment run counter; otherwise clear it.
  - When the run reaches FILT, ab_q takes the new vector and the counter clears.
  - Any intermediate differing vector restarts the run.
- Index filter: same scheme, independent counter, produces idx_q.
- Priming: the first AB acceptance after reset (primed=0) loads ab_q and sets primed. That acceptance produces no count and no err.
- Decode, evaluated on the cycle ab_q changes (old -> new, as {A,B}):
  - Up: 00->10, 10->11, 11->01, 01->00; count+1, dir<=1.
  - Down: the reverse of each up transition; count-1, dir<=0.
  - Both bits changed: err<=1; count and dir unchanged.
- Count arithmetic: modulo 2^W; all-ones +1 gives 0, 0 -1 gives all-ones. No saturation.
- Latency: count changes on the clk edge after the FILT-th matching sample, which is 3+FILT clk after the input edge when sample_en=1.
- Index capture: on idx_q 0->1 while idx_arm=1, idx_pos <= registered count (the value before any same-cycle step) and idx_seen<=1. Falling edges and disarmed edges are ignored.
- snap: count_snap <= registered count (pre-update value) on the next edge. count_snap holds between pulses.
- clr: next edge sets count=0, err=0, idx_seen=0. idx_pos is untouched.
- Priority within one cycle: clr over step and over the index reset feature.
  - snap with clr in the same cycle: count_snap receives the pre-clear value.
  - Index edge with clr in the same cycle: idx_pos captures the pre-clear value, but idx_seen ends 0.
- Reset mid-frame: all outputs return to 0 immediately; the primed flag is cleared, so the next acceptance re-primes.

Optional Feature:
- Macro: QUAD_IDX_RESET_EN.
- Defined: an armed index capture also forces count to 0 on the same edge, overriding a same-cycle step. Homing therefore zeroes position at the index mark.
- Undefined: an index capture only latches idx_pos and idx_seen; count is unaffected.

Test Plan:
- Reset release with A=B=1, sample_en=1, FILT=3 -> after priming count=0, err=0. Then 4 up steps 11->01->00->10->11, each held 10 clk -> count=4, dir=1.
- count=0, one down step 00->01 -> count=0xFFFF, dir=0. One up step back -> count=0x0000.
- A glitch lasting 2 sample ticks (FILT=3) -> no count change. Direct 00->11 change held -> err=1, count unchanged. Then clr -> err=0, count=0.
- count=0x0123, idx_arm=1, index pulse -> idx_pos=0x0123, idx_seen=1. With idx_arm=0, second pulse at count=0x0200 -> idx_pos stays 0x0123.
- snap and clr in the same cycle at count=0x0042 -> count_snap=0x0042, count=0. Step and clr in the same cycle -> count=0.
- QUAD_IDX_RESET_EN defined, count=0x0300, armed index edge coincident with an up step -> idx_pos=0x0300, count=0. Macro undefined -> count=0x0301.
